// File: rtl/dither_frame_scheduler_pkg.sv
// Shared types for the dither frame scheduler: FSM states, pixel/count
// widths and the metadata word that travels alongside each BRAM read.
package dither_frame_scheduler_pkg;

  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned HCOUNT_W   = 11;
  localparam int unsigned VCOUNT_W   = 10;
  // Widest address any supported frame can need (2^11 x 2^10 pixels).
  localparam int unsigned ADDR_MAX_W = HCOUNT_W + VCOUNT_W;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [PIXEL_W-1:0]  pixel_t;
  typedef logic [HCOUNT_W-1:0] hcount_t;
  typedef logic [VCOUNT_W-1:0] vcount_t;

  // Per-issue metadata, delayed to line up with read data and dither result.
  typedef struct packed {
    logic                  valid;
    logic                  prime;
    hcount_t               hcount;
    vcount_t               vcount;
    logic                  wr_en;
    logic [ADDR_MAX_W-1:0] wr_addr;
    logic                  last_col;
    logic                  last_row;
  } meta_t;

endpackage

// File: rtl/dither_frame_scheduler_if.sv
// Bus bundle between the scheduler and its frame buffer / dither unit.
//   read port : rd_en_out, rd_b_addr_out, rd_e_addr_out -> rd_b_data_in, rd_e_data_in
//   dither    : dith_valid_out, dith_prime_out, dith_hcount_out, dith_vcount_out,
//               dith_b_out, dith_e_out -> upd_pixel_in
//   write-back: wr_en_out, wr_addr_out, wr_data_out
// master = scheduler side, slave = buffer/dither side.
interface dither_frame_scheduler_if
  import dither_frame_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) ();

  logic              rd_en_out;
  logic [ADDR_W-1:0] rd_b_addr_out;
  logic [ADDR_W-1:0] rd_e_addr_out;
  pixel_t            rd_b_data_in;
  pixel_t            rd_e_data_in;

  logic              dith_valid_out;
  logic              dith_prime_out;
  hcount_t           dith_hcount_out;
  vcount_t           dith_vcount_out;
  pixel_t            dith_b_out;
  pixel_t            dith_e_out;
  pixel_t            upd_pixel_in;

  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  pixel_t            wr_data_out;

  modport master (
    output rd_en_out, rd_b_addr_out, rd_e_addr_out,
    output dith_valid_out, dith_prime_out, dith_hcount_out, dith_vcount_out,
    output dith_b_out, dith_e_out,
    output wr_en_out, wr_addr_out, wr_data_out,
    input  rd_b_data_in, rd_e_data_in, upd_pixel_in
  );

  modport slave (
    input  rd_en_out, rd_b_addr_out, rd_e_addr_out,
    input  dith_valid_out, dith_prime_out, dith_hcount_out, dith_vcount_out,
    input  dith_b_out, dith_e_out,
    input  wr_en_out, wr_addr_out, wr_data_out,
    output rd_b_data_in, rd_e_data_in, upd_pixel_in
  );

endinterface

// File: rtl/dither_meta_delay.sv
// Fixed-depth shift register for pipeline metadata (DEPTH >= 1).
//   clk_in, rst_in : clock, synchronous active-low reset (clears all stages)
//   din / dout     : metadata in / metadata DEPTH cycles later
module dither_meta_delay
  import dither_frame_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  meta_t din,
  output meta_t dout
);

  meta_t stages [DEPTH];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/dither_frame_scheduler.sv
// Raster-order frame sequencer for the single-pixel error-diffusion dither unit.
// Per row: one PRIME issue (loads pixel a), WIDTH RUN issues (b = right, e = below),
// then DRAIN so the row's last write-back lands before the next row reads it.
//   clk_in, rst_in       : clock, synchronous active-low reset
//   start_in             : frame start request (honoured only in IDLE)
//   busy_out, done_out   : frame in progress / one-cycle end-of-frame pulse
//   bus (master)         : BRAM read, dither unit, write-back signals
// Optional (`DITHER_STATS_EN`): dither_bit_in, ones_count_out count dithered ones.
module dither_frame_scheduler
  import dither_frame_scheduler_pkg::*;
#(
  parameter int unsigned WIDTH          = 320,
  parameter int unsigned HEIGHT         = 180,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned DITHER_LATENCY = 1,
  parameter int unsigned LINE_GAP       = 4,
  parameter int unsigned ADDR_W         = $clog2(WIDTH * HEIGHT)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  output logic                    busy_out,
  output logic                    done_out,
`ifdef DITHER_STATS_EN
  input  logic                    dither_bit_in,
  output logic [ADDR_W:0]         ones_count_out,
`endif
  dither_frame_scheduler_if.master bus
);

  localparam int unsigned DRAIN_LEN = READ_LATENCY + 1 + DITHER_LATENCY + 1 + LINE_GAP;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN + 1);
  localparam hcount_t            LAST_H   = hcount_t'(WIDTH - 1);
  localparam vcount_t            LAST_V   = vcount_t'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(WIDTH);

  state_t              state;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [ADDR_W-1:0]   row_base;
  hcount_t             h_cur;
  vcount_t             v_cur;
  logic                iss_en;
  logic                iss_prime;
  logic [ADDR_W-1:0]   b_addr;
  logic [ADDR_W-1:0]   e_addr;

  // Frame sequencer; issue-side outputs are loaded on entry to each issue cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      drain_cnt <= '0;
      row_base  <= '0;
      h_cur     <= '0;
      v_cur     <= '0;
      iss_en    <= 1'b0;
      iss_prime <= 1'b0;
      b_addr    <= '0;
      e_addr    <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state     <= PRIME;
            busy_out  <= 1'b1;
            row_base  <= '0;
            v_cur     <= '0;
            h_cur     <= '0;
            iss_en    <= 1'b1;
            iss_prime <= 1'b1;
            b_addr    <= '0;
            e_addr    <= ROW_STEP;
          end
        end
        PRIME: begin
          state     <= RUN;
          iss_prime <= 1'b0;
          h_cur     <= '0;
          b_addr    <= row_base + ADDR_W'(1);
          if (v_cur != LAST_V) e_addr <= row_base + ROW_STEP;
        end
        RUN: begin
          if (h_cur == LAST_H) begin
            state     <= DRAIN;
            iss_en    <= 1'b0;
            drain_cnt <= '0;
          end else begin
            h_cur <= h_cur + hcount_t'(1);
            // b stops at the row's last pixel; its data is masked anyway
            if (h_cur + hcount_t'(1) != LAST_H) b_addr <= b_addr + ADDR_W'(1);
            // on the last row e is held in range; its data and write are dropped
            if (v_cur != LAST_V) e_addr <= e_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) begin
            if (v_cur == LAST_V) begin
              state    <= DONE;
              done_out <= 1'b1;
            end else begin
              state     <= PRIME;
              v_cur     <= v_cur + vcount_t'(1);
              row_base  <= row_base + ROW_STEP;
              h_cur     <= '0;
              iss_en    <= 1'b1;
              iss_prime <= 1'b1;
              b_addr    <= row_base + ROW_STEP;
              if (v_cur + vcount_t'(1) != LAST_V) e_addr <= row_base + ROW_STEP + ROW_STEP;
            end
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Metadata for the current issue cycle.
  meta_t iss_meta;
  meta_t rd_meta;
  meta_t up_meta;
  logic  run_valid;
  logic  last_row_c;

  assign run_valid  = iss_en & ~iss_prime;
  assign last_row_c = (v_cur == LAST_V);

  always_comb begin
    iss_meta          = '0;
    iss_meta.valid    = run_valid;
    iss_meta.prime    = iss_prime;
    iss_meta.hcount   = h_cur;
    iss_meta.vcount   = v_cur;
    iss_meta.wr_en    = run_valid & ~last_row_c;
    iss_meta.wr_addr  = ADDR_MAX_W'(e_addr);
    iss_meta.last_col = run_valid & (h_cur == LAST_H);
    iss_meta.last_row = last_row_c;
  end

  // Align metadata with BRAM read data.
  dither_meta_delay #(.DEPTH(READ_LATENCY)) u_rd_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .din    (iss_meta),
    .dout   (rd_meta)
  );

  // Align metadata with upd_pixel_in (dith register stage plus dither latency).
  dither_meta_delay #(.DEPTH(DITHER_LATENCY + 1)) u_up_delay (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .din    (rd_meta),
    .dout   (up_meta)
  );

  logic              dith_valid;
  logic              dith_prime;
  hcount_t           dith_h;
  vcount_t           dith_v;
  pixel_t            dith_b;
  pixel_t            dith_e;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  pixel_t            wr_data;

  // Dither-unit and write-back output registers with boundary masking.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      dith_valid <= 1'b0;
      dith_prime <= 1'b0;
      dith_h     <= '0;
      dith_v     <= '0;
      dith_b     <= '0;
      dith_e     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      dith_valid <= rd_meta.valid;
      dith_prime <= rd_meta.prime;
      dith_h     <= rd_meta.hcount;
      dith_v     <= rd_meta.vcount;
      dith_b     <= rd_meta.last_col ? '0 : bus.rd_b_data_in;
      dith_e     <= rd_meta.last_row ? '0 : bus.rd_e_data_in;
      wr_en      <= up_meta.wr_en;
      wr_addr    <= ADDR_W'(up_meta.wr_addr);
      wr_data    <= bus.upd_pixel_in;
    end
  end

`ifdef DITHER_STATS_EN
  localparam int unsigned CNT_W = ADDR_W + 1;

  // Ones counter; only advances while a frame's pipeline is active.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      ones_count_out <= '0;
    end else if (state == IDLE && start_in) begin
      ones_count_out <= '0;
    end else if (up_meta.valid && dither_bit_in) begin
      ones_count_out <= ones_count_out + CNT_W'(1);
    end
  end
`endif

  logic unused_meta;
  assign unused_meta = ^up_meta;

  assign bus.rd_en_out       = iss_en;
  assign bus.rd_b_addr_out   = b_addr;
  assign bus.rd_e_addr_out   = e_addr;
  assign bus.dith_valid_out  = dith_valid;
  assign bus.dith_prime_out  = dith_prime;
  assign bus.dith_hcount_out = dith_h;
  assign bus.dith_vcount_out = dith_v;
  assign bus.dith_b_out      = dith_b;
  assign bus.dith_e_out      = dith_e;
  assign bus.wr_en_out       = wr_en;
  assign bus.wr_addr_out     = wr_addr;
  assign bus.wr_data_out     = wr_data;

endmodule
